// File: rtl/mon_fifo_pkg.sv
// Shared constants for the monitor FIFO.
// Defaults for width, depth and almost-full margin.
package mon_fifo_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_AFULL_MARGIN = 4;

endpackage

// File: rtl/mon_fifo_mem.sv
// Simple dual-port storage for the monitor FIFO.
// One write port, one registered read port, no reset.
module mon_fifo_mem
    import mon_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its word between reads
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mon_fifo.sv
// Synchronous FIFO with occupancy flags and sticky overflow.
// Control logic here; storage lives in mon_fifo_mem.
module mon_fifo
    import mon_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - DEF_AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  seen;
    logic                  rd_acc;
    logic                  wr_acc;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AFULL_C);

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // mem_q is unreset, so show zero until the first read after reset
    assign rd_data = seen ? mem_q : '0;

    mon_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc && !rst),
        .raddr (rd_ptr),
        .rdata (mem_q)
    );

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                wr_acc && !rd_acc: count <= count + 1'b1;
                rd_acc && !wr_acc: count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Read qualifier, tracked alongside the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            seen     <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                seen <= 1'b1;
            end
        end
    end

    // Sticky overflow; a dropped write beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && !wr_acc) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mon_fifo.sv
// Randomized and directed bench for mon_fifo.
// Outputs are compared each cycle against a queue model.
module tb_mon_fifo;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFULL = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd;
    logic          m_rv;
    logic          m_ovf;

    mon_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: drive, update model from pre-edge state, check after edge
    task automatic step(input logic r, input logic w,
                        input logic [DW-1:0] d,
                        input logic rd, input logic c);
        logic racc;
        logic wacc;
        rst          = r;
        wr_en        = w;
        wr_data      = d;
        rd_en        = rd;
        clr_overflow = c;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_rd  = '0;
            m_rv  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            racc = rd && (q.size() > 0);
            wacc = w && ((q.size() < DEPTH) || racc);
            m_rv = racc;
            if (racc) m_rd = q.pop_front();
            if (wacc) q.push_back(d);
            if (w && !wacc) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        #1;
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full),
            32'(q.size() >= AFULL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rdo();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int wp;
        int rp;
        logic [DW-1:0] wd;
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        m_rd  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;

        do_rst();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        // Three words in, three out
        for (int i = 1; i <= 3; i++) wr(DW'(i));
        for (int i = 1; i <= 3; i++) begin
            rdo();
            chk("seq_data", 32'(rd_data), i);
        end
        idle();
        chk("seq_empty", 32'(empty), 32'd1);

        // Fill, overflow, clear
        do_rst();
        for (int i = 0; i < DEPTH; i++) wr(DW'(16'h100 + i));
        chk("fill_full", 32'(full), 32'd1);
        wr(16'hDEAD);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);

        // Read+write while full
        step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("full_rw_cnt", 32'(count), DEPTH);
        chk("full_rw_old", 32'(rd_data), 32'h100);
        for (int i = 0; i < DEPTH; i++) rdo();
        chk("beef_last", 32'(rd_data), 32'hBEEF);

        // Read+write while empty
        step(1'b0, 1'b1, 16'h5A5A, 1'b1, 1'b0);
        chk("empty_rw_rv", 32'(rd_valid), 32'd0);
        chk("empty_rw_cnt", 32'(count), 32'd1);
        rdo();
        chk("empty_rw_data", 32'(rd_data), 32'h5A5A);

        // Alternating traffic across 70 words
        for (int i = 0; i < 70; i++) begin
            wr(DW'($urandom));
            rdo();
        end

        // Reset mid-operation
        for (int i = 0; i < 10; i++) wr(DW'(16'h200 + i));
        step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        wr(16'h4321);
        rdo();
        chk("mid_rst_data", 32'(rd_data), 32'h4321);

        // Random traffic with drifting write/read bias
        for (int ph = 0; ph < 8; ph++) begin
            wp = (ph % 2 == 0) ? 85 : 25;
            rp = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 300; i++) begin
                wd = DW'($urandom);
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < wp), wd,
                     ($urandom_range(0, 99) < rp),
                     ($urandom_range(0, 19) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mon_fifo.md
MON_FIFO -- requirements
Module: mon_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, giving a depth of DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4, the almost_full threshold in words; legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: write request.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH bits: write word.
REQ-008 SHALL have port rd_en, input, 1 bit: read request.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH bits: read word, qualified by rd_valid.
REQ-010 SHALL have port rd_valid, output, 1 bit: rd_data holds the word of the read accepted in the previous cycle.
REQ-011 SHALL have port empty, output, 1 bit: count == 0.
REQ-012 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 SHALL have port almost_full, output, 1 bit: count >= AFULL_LEVEL.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1 bits: number of stored words, 0..DEPTH.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-016 SHALL have port clr_overflow, input, 1 bit: clears overflow.

Function
REQ-017 Write accepted = wr_en && (!full || rd_accept); an accepted write stores wr_data at the write pointer, and the pointer increments modulo DEPTH.
REQ-018 Read accepted (rd_accept) = rd_en && !empty; the read pointer increments modulo DEPTH.
REQ-019 Read latency is 1 cycle: rd_data and rd_valid are registered, and the word appears the cycle after rd_accept.
REQ-020 rd_data holds its last value while rd_valid is low.
REQ-021 count updates the cycle after the request: +1 for a write only, -1 for a read only, unchanged for both or neither; empty, full and almost_full derive combinationally from the registered count.
REQ-022 Simultaneous read and write when full: both are accepted, count stays DEPTH, and the read returns the oldest word (no overwrite).
REQ-023 Simultaneous read and write when empty: only the write is accepted (no bypass), and count becomes 1.
REQ-024 rd_en while empty is ignored: no pointer change, rd_valid = 0, and no error flag is raised.
REQ-025 wr_en while full without rd_accept drops the word and sets overflow in the next cycle.
REQ-026 overflow stays set until clr_overflow; if a set condition and clr_overflow coincide, the set wins.
REQ-027 Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no gap.

Reset
REQ-028 While rst is high at a clk edge: pointers = 0, count = 0, rd_valid = 0, overflow = 0, rd_data = 0, so empty = 1, full = 0, almost_full = 0.
REQ-029 Memory contents SHALL NOT be reset; a reset mid-operation discards all stored words, and requests in the reset cycle are ignored.
REQ-030 The first request is accepted in the first cycle with rst low.

Structure
REQ-031 Package mon_fifo_pkg SHALL hold the default width, address width and almost-full margin constants.
REQ-032 Storage SHALL be sub-module mon_fifo_mem: simple dual-port array, one write port, registered read port, no reset; the FIFO control logic stays in mon_fifo.

Verification
REQ-033 Reset, then write 0x0001..0x0003, then 3 reads -> rd_data 0x0001, 0x0002, 0x0003, each one cycle after its rd_en; empty = 1 after the third read.
REQ-034 Defaults, write 32 words -> full = 1, count = 32, almost_full set from count 28; 33rd write -> dropped and overflow = 1; clr_overflow -> overflow = 0.
REQ-035 Full, then rd_en and wr_en together with 0xBEEF -> count stays 32, rd_data = oldest word, and 0xBEEF is read last after 32 further reads.
REQ-036 Empty, then rd_en and wr_en together -> rd_valid = 0, count = 1, and the next read returns the written word.
REQ-037 Write and read alternately across 70 words -> pointers wrap twice, and data matches a reference queue with no loss.
REQ-038 rst asserted with count = 10 -> count = 0, empty = 1, rd_valid = 0 next cycle, and the next read after one write returns the new word.
